// File: rtl/bmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bmp_pkg
// Description : Shared constants, header byte offsets and receiver state type
//               for the word-packed BMP stream receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package bmp_pkg;

    // Byte offsets of the parsed little-endian header fields
    localparam int OFS_SIG    = 0;
    localparam int OFS_SIZE   = 2;
    localparam int OFS_START  = 10;
    localparam int OFS_WIDTH  = 18;
    localparam int OFS_HEIGHT = 22;
    localparam int OFS_BITCNT = 28;

    // "BM" file signature
    localparam logic [7:0] BMP_SIG0 = 8'h42;
    localparam logic [7:0] BMP_SIG1 = 8'h4D;

    typedef enum logic [2:0] {
        HEADER = 3'd0,
        SKIP   = 3'd1,
        PIXEL  = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } rx_state_t;

    // Replace byte 'sel' of a 32-bit little-endian field
    function automatic logic [31:0] put_byte(input logic [31:0] field,
                                             input logic [1:0]  sel,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = field;
        case (sel)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/word_to_byte_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : word_to_byte_unpacker
// Description : Single-word buffer that presents a packed input word one
//               byte lane at a time (lane 0 first). A new word is accepted
//               while the last lane is being consumed, so back-to-back words
//               flow without a bubble. 'byte_flush' drops the remaining lanes
//               with the current take; 'drain' discards everything.
// Revision    : 1.0 - initial release
// ============================================================================
module word_to_byte_unpacker #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  drain,
    output logic [BYTE-1:0]       byte_data,
    output logic                  byte_valid,
    input  logic                  byte_take,
    input  logic                  byte_flush
);

    localparam int LANES = DATA_WIDTH / BYTE;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_full;
    logic [LW-1:0]         r_lane;

    logic [BYTE-1:0]       w_lanes [LANES];
    logic                  w_take;
    logic                  w_lane_last;
    logic                  w_accept;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_lanes[gi] = r_word[gi*BYTE +: BYTE];
    end

    assign w_take      = r_full & byte_take;
    assign w_lane_last = (r_lane == LW'(LANES - 1));
    assign in_ready    = ~rst & (~r_full | (w_take & w_lane_last) | drain);
    assign w_accept    = in_valid & in_ready;

    assign byte_valid  = r_full;
    assign byte_data   = w_lanes[r_lane];

    // Word buffer and lane pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
            r_full <= 1'b0;
            r_lane <= '0;
        end else if (drain) begin
            r_full <= 1'b0;
            r_lane <= '0;
        end else if (w_accept) begin
            r_word <= in_data;
            r_full <= 1'b1;
            r_lane <= '0;
        end else if (w_take) begin
            if (byte_flush || w_lane_last) begin
                r_full <= 1'b0;
                r_lane <= '0;
            end else begin
                r_lane <= r_lane + LW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bmp_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module      : bmp_stream_receiver
// Description : Receives a word-packed BMP byte stream, parses the header,
//               skips the gap up to the pixel array and emits pixel bytes
//               one per cycle with a ready/valid handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bmp_stream_receiver
    import bmp_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE          = 8,
    parameter int HDR_LEN       = 30,
    parameter int BMP_ARRAY_LEN = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_cmplt,
    output logic [BYTE-1:0]       pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_last,
    output logic [31:0]           file_size,
    output logic [31:0]           data_start_pos,
    output logic [31:0]           p_width,
    output logic [31:0]           p_height,
    output logic [15:0]           p_biBitCount,
    output logic                  hdr_valid,
    output logic                  done,
    output logic                  err_sig,
    output logic                  err_hdr,
    output logic                  err_short
);

    rx_state_t   r_state;
    logic [31:0] r_idx;
    logic [31:0] r_file_size;
    logic [31:0] r_start;
    logic [31:0] r_width;
    logic [31:0] r_height;
    logic [15:0] r_bitcnt;
    logic        r_hdr_valid;
    logic        r_done;
    logic        r_err_sig;
    logic        r_err_hdr;
    logic        r_err_short;
    logic        r_cmplt;

    logic [BYTE-1:0] w_byte;
    logic            w_byte_valid;
    logic            w_take;
    logic            w_flush;
    logic            w_drain;
    logic            w_is_last;
    logic            w_active;
    logic            w_short;
    logic            w_hdr_bad;
    logic [31:0]     w_rel_size;
    logic [31:0]     w_rel_start;
    logic [31:0]     w_rel_width;
    logic [31:0]     w_rel_height;

    word_to_byte_unpacker #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE       (BYTE)
    ) u_unpack (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .drain      (w_drain),
        .byte_data  (w_byte),
        .byte_valid (w_byte_valid),
        .byte_take  (w_take),
        .byte_flush (w_flush)
    );

    assign w_drain   = (r_state == DONE) || (r_state == ERROR);
    assign w_is_last = (r_idx == r_file_size - 32'd1);
    assign w_active  = (r_state == HEADER) || (r_state == SKIP) || (r_state == PIXEL);
    // Sender finished but the stream ran dry before the file completed
    assign w_short   = r_cmplt & ~w_byte_valid & w_active;
    assign w_hdr_bad = (r_start < 32'(HDR_LEN)) || (r_file_size <= r_start) ||
                       (r_file_size > 32'(BMP_ARRAY_LEN));

    // Position of the current byte inside each multi-byte field (wraps when outside)
    assign w_rel_size   = r_idx - 32'(OFS_SIZE);
    assign w_rel_start  = r_idx - 32'(OFS_START);
    assign w_rel_width  = r_idx - 32'(OFS_WIDTH);
    assign w_rel_height = r_idx - 32'(OFS_HEIGHT);

    // Byte consumption per state; the final pixel byte also drops the rest of its word
    always_comb begin
        w_take  = 1'b0;
        w_flush = 1'b0;
        case (r_state)
            HEADER: w_take = w_byte_valid & ~r_hdr_valid;
            SKIP:   w_take = w_byte_valid;
            PIXEL: begin
                w_take  = w_byte_valid & pix_ready;
                w_flush = w_is_last;
            end
            default: begin
                w_take  = 1'b0;
                w_flush = 1'b0;
            end
        endcase
    end

    // Receiver FSM, byte index, header fields and sticky status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HEADER;
            r_idx       <= '0;
            r_file_size <= '0;
            r_start     <= '0;
            r_width     <= '0;
            r_height    <= '0;
            r_bitcnt    <= '0;
            r_hdr_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err_sig   <= 1'b0;
            r_err_hdr   <= 1'b0;
            r_err_short <= 1'b0;
            r_cmplt     <= 1'b0;
        end else begin
            if (in_cmplt) begin
                r_cmplt <= 1'b1;
            end
            if (w_short) begin
                r_state     <= ERROR;
                r_err_short <= 1'b1;
            end else begin
                case (r_state)
                    HEADER: begin
                        if (r_hdr_valid) begin
                            // All header bytes captured: validate once, then branch
                            if (w_hdr_bad) begin
                                r_state   <= ERROR;
                                r_err_hdr <= 1'b1;
                            end else if (r_start == 32'(HDR_LEN)) begin
                                r_state <= PIXEL;
                            end else begin
                                r_state <= SKIP;
                            end
                        end else if (w_take) begin
                            r_idx <= r_idx + 32'd1;
                            if (((r_idx == 32'(OFS_SIG))     && (w_byte[7:0] != BMP_SIG0)) ||
                                ((r_idx == 32'(OFS_SIG + 1)) && (w_byte[7:0] != BMP_SIG1))) begin
                                r_state   <= ERROR;
                                r_err_sig <= 1'b1;
                            end
                            if (w_rel_size < 32'd4) begin
                                r_file_size <= put_byte(r_file_size, w_rel_size[1:0], w_byte[7:0]);
                            end
                            if (w_rel_start < 32'd4) begin
                                r_start <= put_byte(r_start, w_rel_start[1:0], w_byte[7:0]);
                            end
                            if (w_rel_width < 32'd4) begin
                                r_width <= put_byte(r_width, w_rel_width[1:0], w_byte[7:0]);
                            end
                            if (w_rel_height < 32'd4) begin
                                r_height <= put_byte(r_height, w_rel_height[1:0], w_byte[7:0]);
                            end
                            if (r_idx == 32'(OFS_BITCNT)) begin
                                r_bitcnt[7:0] <= w_byte[7:0];
                            end
                            if (r_idx == 32'(OFS_BITCNT + 1)) begin
                                r_bitcnt[15:8] <= w_byte[7:0];
                            end
                            if (r_idx == 32'(HDR_LEN - 1)) begin
                                r_hdr_valid <= 1'b1;
                            end
                        end
                    end
                    SKIP: begin
                        if (w_take) begin
                            r_idx <= r_idx + 32'd1;
                            if (r_idx == r_start - 32'd1) begin
                                r_state <= PIXEL;
                            end
                        end
                    end
                    PIXEL: begin
                        if (w_take) begin
                            r_idx <= r_idx + 32'd1;
                            if (w_is_last) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign pix_valid      = (r_state == PIXEL) & w_byte_valid;
    assign pix_data       = w_byte;
    assign pix_last       = pix_valid & w_is_last;
    assign file_size      = r_file_size;
    assign data_start_pos = r_start;
    assign p_width        = r_width;
    assign p_height       = r_height;
    assign p_biBitCount   = r_bitcnt;
    assign hdr_valid      = r_hdr_valid;
    assign done           = r_done;
    assign err_sig        = r_err_sig;
    assign err_hdr        = r_err_hdr;
    assign err_short      = r_err_short;

endmodule
`default_nettype wire
